sram_sched: RTL



---
 rtl/sram_sched_pkg.sv | 20 ++
 rtl/sram_sched.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/sram_sched_pkg.sv
// Shared types and constants for the external SRAM scheduler.
package sram_sched_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    VIDEO  = 3'd1,
    CPU    = 3'd2,
    LOADER = 3'd3,
    TURN   = 3'd4
  } sram_state_t;

  localparam int SRAM_TURN_CYCLES = 1;
  localparam int SRAM_CNT_W       = 2;

  // Slot counters run 0..cycles-1; this is the value on the final cycle.
  function automatic logic [SRAM_CNT_W-1:0] last_cnt(input int cycles);
    return SRAM_CNT_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/sram_sched.sv
// Shared external SRAM scheduler: video > cpu > loader, fixed-length slots, write turnaround.
// Optional loader anti-starvation promotion: define SRAM_SCHED_STARVE_EN.
module sram_sched #(
  parameter int VIDEO_CYCLES  = 2,
  parameter int CPU_CYCLES    = 3,
  parameter int LOADER_CYCLES = 3
`ifdef SRAM_SCHED_STARVE_EN
  , parameter int STARVE_LIMIT = 15
`endif
) (
  input  logic        clk28,
  input  logic        rst,
  input  logic        video_req,
  input  logic [14:0] video_addr,
  output logic        video_ack,
  output logic [7:0]  video_data,
  input  logic        cpu_req,
  input  logic        cpu_wr,
  output logic        cpu_wait,
  input  logic        loader_req,
  output logic        loader_ack,
  output logic        grant_video,
  output logic        grant_cpu,
  output logic        grant_loader,
  output logic        sram_rd,
  output logic        sram_wr,
  input  logic [7:0]  vd_in
);

  import sram_sched_pkg::*;

  localparam logic [SRAM_CNT_W-1:0] VIDEO_LAST  = last_cnt(VIDEO_CYCLES);
  localparam logic [SRAM_CNT_W-1:0] CPU_LAST    = last_cnt(CPU_CYCLES);
  localparam logic [SRAM_CNT_W-1:0] LOADER_LAST = last_cnt(LOADER_CYCLES);
  localparam logic [SRAM_CNT_W-1:0] TURN_LAST   = last_cnt(SRAM_TURN_CYCLES);

  sram_state_t            state_q, state_d;
  logic [SRAM_CNT_W-1:0]  cnt_q, cnt_d;
  logic                   cpu_wr_q, cpu_wr_d;
  logic                   video_ack_q, video_ack_d;
  logic                   loader_ack_q, loader_ack_d;
  logic [7:0]             video_data_q, video_data_d;
  logic                   grant_video_q, grant_cpu_q, grant_loader_q;
  logic                   sram_rd_q, sram_wr_q;
  logic                   video_elig;
  logic                   promote;

  // The address goes straight to the memory mux; the scheduler never looks at it.
  logic video_addr_unused;
  assign video_addr_unused = ^video_addr;

  // A synchronous requester still shows its request in the ack cycle; that is the byte just served.
  assign video_elig = video_req & ~video_ack_q;

`ifdef SRAM_SCHED_STARVE_EN
  localparam int                  STARVE_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  logic [STARVE_W-1:0] starve_q, starve_d;

  assign promote = (starve_q == STARVE_MAX);

  always_comb begin
    starve_d = starve_q;
    if (state_q == IDLE) begin
      if (state_d == LOADER) begin
        starve_d = '0;
      end else if (loader_req && (state_d != IDLE) && (starve_q != STARVE_MAX)) begin
        starve_d = starve_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk28) begin
    if (rst) starve_q <= '0;
    else     starve_q <= starve_d;
  end
`else
  assign promote = 1'b0;
`endif

  always_comb begin
    // NOTE: every signal gets a default here so no path leaves one unassigned and infers a latch.
    state_d      = state_q;
    cnt_d        = cnt_q + 1'b1;
    cpu_wr_d     = cpu_wr_q;
    video_ack_d  = 1'b0;
    loader_ack_d = 1'b0;
    video_data_d = video_data_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (video_elig) begin
          state_d = VIDEO;
        end else if (promote && loader_req) begin
          state_d = LOADER;
        end else if (cpu_req) begin
          state_d  = CPU;
          cpu_wr_d = cpu_wr;
        end else if (loader_req) begin
          state_d = LOADER;
        end
      end
      VIDEO: if (cnt_q == VIDEO_LAST) begin
        state_d      = IDLE;
        cnt_d        = '0;
        video_data_d = vd_in;
        video_ack_d  = 1'b1;
      end
      CPU: if (cnt_q == CPU_LAST) begin
        state_d = cpu_wr_q ? TURN : IDLE;
        cnt_d   = '0;
      end
      LOADER: if (cnt_q == LOADER_LAST) begin
        state_d      = TURN;
        cnt_d        = '0;
        loader_ack_d = 1'b1;
      end
      TURN: if (cnt_q == TURN_LAST) begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk28) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      cpu_wr_q       <= 1'b0;
      video_ack_q    <= 1'b0;
      loader_ack_q   <= 1'b0;
      video_data_q   <= 8'h00;
      grant_video_q  <= 1'b0;
      grant_cpu_q    <= 1'b0;
      grant_loader_q <= 1'b0;
      sram_rd_q      <= 1'b0;
      sram_wr_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      cpu_wr_q       <= cpu_wr_d;
      video_ack_q    <= video_ack_d;
      loader_ack_q   <= loader_ack_d;
      video_data_q   <= video_data_d;
      grant_video_q  <= (state_d == VIDEO);
      grant_cpu_q    <= (state_d == CPU);
      grant_loader_q <= (state_d == LOADER);
      sram_rd_q      <= (state_d == VIDEO)  | ((state_d == CPU) & ~cpu_wr_d);
      sram_wr_q      <= (state_d == LOADER) | ((state_d == CPU) &  cpu_wr_d);
    end
  end

  assign grant_video  = grant_video_q;
  assign grant_cpu    = grant_cpu_q;
  assign grant_loader = grant_loader_q;
  assign sram_rd      = sram_rd_q;
  assign sram_wr      = sram_wr_q;
  assign video_ack    = video_ack_q;
  assign loader_ack   = loader_ack_q;
  assign video_data   = video_data_q;
  assign cpu_wait     = cpu_req & ~grant_cpu_q & ~rst;

endmodule
